fsmc_slave_arbiter: RTL
=======================

// Module: fsmc_slave_arbiter
// PURPOSE
//   Transaction sequencer between fsmc_interface user port and NUM_SLAVES on-chip slaves.
//   Turns one-hot cs / state / rd_data into per-slave req/ack transfers.
//   Returns read data on bus_wr_data and bounds every transfer with a timeout.
//   Sits directly behind fsmc_interface in the FPGA top level; owns all slave sequencing.
// PARAMETERS
//   NUM_SLAVES      4        slave count; equals width of cs (2**CS_WIDTH)
//   DATA_WIDTH      16       FSMC data width
//   SLV_ADDR_WIDTH  8        slave-local address = bus_rd_data[SLV_ADDR_WIDTH-1:0] at start
//   TIMEOUT_CYCLES  8        clk cycles to wait for slv_ack before abort (>=2)
//   TIMEOUT_DATA    16'hDEAD value returned on a timed-out read
// PORTS
//   clk           in   1                     system clock
//   reset_n       in   1                     asynchronous reset, active-low
//   bus_rd_data   in   DATA_WIDTH            fsmc_interface rd_data (address, then write data)
//   bus_state     in   1                     fsmc_interface state: 1 read, 0 write
//   bus_cs        in   NUM_SLAVES            fsmc_interface cs, one-hot or zero
//   bus_wr_data   out  DATA_WIDTH            read-back data to fsmc_interface wr_data
//   slv_req       out  NUM_SLAVES            one-hot request, held until ack or timeout
//   slv_we        out  1                     1 write, 0 read; valid while slv_req != 0
//   slv_addr      out  SLV_ADDR_WIDTH        latched slave address
//   slv_wdata     out  DATA_WIDTH            write data; valid while slv_req != 0 and slv_we
//   slv_ack       in   NUM_SLAVES            one-cycle per-slave acknowledge
//   slv_rdata     in   NUM_SLAVES*DATA_WIDTH packed read data; slave i at [i*DW +: DW], valid with ack
//   busy          out  1                     high in every state except IDLE
//   err_timeout   out  1                     one-cycle pulse on timeout abort
//   err_overrun   out  1                     one-cycle pulse on dropped or illegal start
//   stat_timeouts out  16                    saturating timeout count (optional feature)
//   stat_overruns out  16                    saturating overrun count (optional feature)
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; slv_idx/addr/wdata registers 0.
//   Start event: bus_cs one-hot and (previous-cycle cs == 0, or different from previous-cycle cs).
//     On start, latch slv_idx, slv_addr and bus_state.
//   Illegal cs (more than one bit set): no start; err_overrun pulse on first cycle only.
//   FSM states: IDLE, RD_REQ, WR_WAIT, WR_REQ.
//   IDLE, start with state=1 -> RD_REQ.
//     slv_req[idx]=1 and slv_we=0 from the next cycle.
//   RD_REQ:
//     slv_ack[idx] -> bus_wr_data <= slv_rdata[idx], req drops the same edge -> IDLE.
//     Acks on other bits are ignored.
//   IDLE, start with state=0 -> WR_WAIT.
//     Wait for bus_cs == 0, i.e. write data captured by fsmc_interface.
//     On cs==0: slv_wdata <= bus_rd_data -> WR_REQ; slv_req[idx]=1, slv_we=1 next cycle.
//   WR_REQ: slv_ack[idx] -> IDLE.
//   Timeout:
//     Counter loads TIMEOUT_CYCLES on entry to RD_REQ/WR_REQ and decrements each cycle.
//     Counter 0 without ack -> req dropped, err_timeout pulse -> IDLE.
//     On a read timeout, bus_wr_data <= TIMEOUT_DATA.
//   Ack and timeout on the same cycle: ack wins, no error.
//   Start while busy (any state != IDLE, including a new one-hot start in WR_WAIT):
//     start dropped, err_overrun pulse; current transfer continues.
//   bus_wr_data holds its last value until the next read completes or times out.
//   Latency (start edge = cycle 0):
//     req at cycle 1; read data on bus_wr_data 1 cycle after ack.
//     Idle after ack: IDLE at cycle N+1, where N is the ack cycle.
//   reset_n assertion mid-transfer: immediate abort, all outputs to reset values, no error pulse.
// CONFIGURATION
//   FSMC_ARB_STATS_EN defined:
//     stat_timeouts and stat_overruns increment on each err pulse, saturating at 16'hFFFF.
//     Cleared only by reset.
//   FSMC_ARB_STATS_EN undefined:
//     stat_* tied to 0, no counter flops; all other behaviour identical.
// STRUCTURE
//   Package fsmc_arb_pkg:
//     arb_state_t enum {IDLE, RD_REQ, WR_WAIT, WR_REQ}
//     STAT_WIDTH = 16
//     function onehot_valid(): exactly one bit set
//   Sub-module fsmc_onehot_enc:
//     combinational one-hot -> index, plus valid flag.
//     Used for cs decode and slv_rdata mux select.
// TESTING
//   1. Read slave 2, addr 8'h34, ack after 3 cycles with rdata 16'hA55A:
//      slv_req=4'b0100 for 3 cycles; bus_wr_data=16'hA55A; no errors.
//   2. Write slave 1, addr 8'h10; cs clears with bus_rd_data=16'h1234; ack at once:
//      slv_we=1, slv_addr=8'h10, slv_wdata=16'h1234, req for 1 cycle.
//   3. Read slave 0, no ack:
//      req for 8 cycles, then err_timeout pulse, bus_wr_data=16'hDEAD, busy falls.
//   4. Second cs start during a pending write to slave 3:
//      err_overrun pulse; write still completes with original addr/data.
//   5. bus_cs=4'b0110:
//      no slv_req; one err_overrun pulse.
//      With FSMC_ARB_STATS_EN, stat_overruns increments by 1.
//   6. reset_n low during RD_REQ:
//      slv_req=0, busy=0, bus_wr_data=0 immediately; next read works normally.

Source files
------------

// File: rtl/fsmc_arb_pkg.sv
// Shared types and helpers for the FSMC slave arbiter.
package fsmc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    WR_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } arb_state_t;

  localparam int STAT_WIDTH = 16;

  // True when exactly one bit is set; callers zero-extend narrower vectors.
  function automatic logic onehot_valid(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/fsmc_onehot_enc.sv
// Combinational one-hot to binary index encoder with a valid (exactly-one-bit) flag.
module fsmc_onehot_enc
  import fsmc_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
  end

  assign valid = onehot_valid(32'(onehot));

endmodule

// File: rtl/fsmc_slave_arbiter.sv
// Sequences fsmc_interface cs/state/rd_data into per-slave req/ack transfers with timeout.
// Optional saturating error statistics when FSMC_ARB_STATS_EN is defined.
module fsmc_slave_arbiter
  import fsmc_arb_pkg::*;
#(
  parameter int                  NUM_SLAVES     = 4,
  parameter int                  DATA_WIDTH     = 16,
  parameter int                  SLV_ADDR_WIDTH = 8,
  parameter int                  TIMEOUT_CYCLES = 8,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [DATA_WIDTH-1:0]            bus_rd_data,
  input  logic                             bus_state,
  input  logic [NUM_SLAVES-1:0]            bus_cs,
  output logic [DATA_WIDTH-1:0]            bus_wr_data,
  output logic [NUM_SLAVES-1:0]            slv_req,
  output logic                             slv_we,
  output logic [SLV_ADDR_WIDTH-1:0]        slv_addr,
  output logic [DATA_WIDTH-1:0]            slv_wdata,
  input  logic [NUM_SLAVES-1:0]            slv_ack,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata,
  output logic                             busy,
  output logic                             err_timeout,
  output logic                             err_overrun,
  output logic [STAT_WIDTH-1:0]            stat_timeouts,
  output logic [STAT_WIDTH-1:0]            stat_overruns
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0]     cs_prev_q, cs_prev_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [SLV_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      err_to_q, err_to_d;
  logic                      err_ov_q, err_ov_d;

  logic [IW-1:0] cs_idx, ack_idx;
  logic          cs_valid, ack_hit;
  logic          start, illegal_new, timer_zero, in_req;

  fsmc_onehot_enc #(.N(NUM_SLAVES), .IW(IW)) u_cs_enc (
    .onehot (bus_cs),
    .idx    (cs_idx),
    .valid  (cs_valid)
  );

  // Only the addressed slave's ack is visible; acks on other bits are masked off.
  fsmc_onehot_enc #(.N(NUM_SLAVES), .IW(IW)) u_ack_enc (
    .onehot (slv_ack & slv_req),
    .idx    (ack_idx),
    .valid  (ack_hit)
  );

  // A valid one-hot cs is never zero, so "changed from previous" also covers "previous was zero".
  assign start       = cs_valid && (bus_cs != cs_prev_q);
  assign illegal_new = (bus_cs != '0) && !cs_valid && (bus_cs != cs_prev_q);
  assign timer_zero  = (timer_q == '0);
  assign in_req      = (state_q == RD_REQ) || (state_q == WR_REQ);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = bus_state ? RD_REQ : WR_WAIT;
      RD_REQ:  if (ack_hit || timer_zero) state_d = IDLE;
      WR_WAIT: if (bus_cs == '0) state_d = WR_REQ;
      WR_REQ:  if (ack_hit || timer_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slv_req = '0;
    if (in_req) slv_req[idx_q] = 1'b1;
    slv_we = (state_q == WR_REQ);
    busy   = (state_q != IDLE);
  end

  // Timer holds the number of request cycles left after the current one.
  always_comb begin
    cs_prev_d = bus_cs;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    timer_d   = timer_q;
    err_to_d  = 1'b0;
    err_ov_d  = illegal_new || (start && (state_q != IDLE));

    if (in_req && !timer_zero) timer_d = timer_q - TW'(1);

    unique case (state_q)
      IDLE: if (start) begin
        idx_d   = cs_idx;
        addr_d  = bus_rd_data[SLV_ADDR_WIDTH-1:0];
        timer_d = TW'(TIMEOUT_CYCLES - 1);
      end
      WR_WAIT: if (bus_cs == '0) begin
        wdata_d = bus_rd_data;
        timer_d = TW'(TIMEOUT_CYCLES - 1);
      end
      RD_REQ: begin
        if (ack_hit) rdata_d = slv_rdata[ack_idx*DATA_WIDTH +: DATA_WIDTH];
        else if (timer_zero) begin
          rdata_d  = TIMEOUT_DATA;
          err_to_d = 1'b1;
        end
      end
      WR_REQ: if (!ack_hit && timer_zero) err_to_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_prev_q <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      timer_q   <= '0;
      err_to_q  <= 1'b0;
      err_ov_q  <= 1'b0;
    end else begin
      cs_prev_q <= cs_prev_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      timer_q   <= timer_d;
      err_to_q  <= err_to_d;
      err_ov_q  <= err_ov_d;
    end
  end

  assign bus_wr_data = rdata_q;
  assign slv_addr    = addr_q;
  assign slv_wdata   = wdata_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

`ifdef FSMC_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_to_q, stat_to_d;
  logic [STAT_WIDTH-1:0] stat_ov_q, stat_ov_d;

  // Counters step together with the error pulse they record and stick at all-ones.
  always_comb begin
    stat_to_d = stat_to_q;
    stat_ov_d = stat_ov_q;
    if (err_to_d && (stat_to_q != '1)) stat_to_d = stat_to_q + STAT_WIDTH'(1);
    if (err_ov_d && (stat_ov_q != '1)) stat_ov_d = stat_ov_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_to_q <= '0;
      stat_ov_q <= '0;
    end else begin
      stat_to_q <= stat_to_d;
      stat_ov_q <= stat_ov_d;
    end
  end

  assign stat_timeouts = stat_to_q;
  assign stat_overruns = stat_ov_q;
`else
  assign stat_timeouts = '0;
  assign stat_overruns = '0;
`endif

endmodule
